// File: rtl/mem_pkg.sv
// Shared types and helpers for the data-RAM initiator: access sizes, FSM states,
// byte-lane masks and the alignment rule.
package mem_pkg;

  typedef enum logic [1:0] {
    MEM_B = 2'd0,
    MEM_H = 2'd1,
    MEM_W = 2'd2,
    MEM_D = 2'd3
  } mem_size_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    RESP  = 2'd3
  } mem_state_e;

  // Widest word supported by the mask helper, in bytes.
  localparam int unsigned MAX_BYTES = 64;

  function automatic logic [MAX_BYTES-1:0] byte_mask(input mem_size_e size,
                                                     input int unsigned offset);
    logic [MAX_BYTES-1:0] base;
    base = MAX_BYTES'((64'd1 << (32'd1 << size)) - 64'd1);
    return base << offset;
  endfunction

  // An access is misaligned when the byte offset is not a multiple of its size.
  function automatic logic is_misaligned(input mem_size_e size, input int unsigned low);
    return (low & ((32'd1 << size) - 32'd1)) != 32'd0;
  endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Request/response handshake plus data-RAM port of the load/store initiator.
// The slave modport is the controller's view; master is the core/RAM side.
interface mem_access_ctrl_if #(
  parameter int DATA_WIDTH = 64,
  parameter int ADR_WIDTH  = DATA_WIDTH
);

  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [1:0]            req_size;
  logic                  req_unsigned;
  logic [ADR_WIDTH-1:0]  req_adr;
  logic [DATA_WIDTH-1:0] req_wdata;

  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_err;

  logic                  mem_we;
  logic [ADR_WIDTH-1:0]  mem_adr;
  logic [DATA_WIDTH-1:0] mem_din;
  logic [DATA_WIDTH-1:0] mem_dout;

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_adr, req_wdata,
    input  rsp_ready, mem_dout,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
    output mem_we, mem_adr, mem_din
  );

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_adr, req_wdata,
    output rsp_ready, mem_dout,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
    input  mem_we, mem_adr, mem_din
  );

endinterface

// File: rtl/mem_lane_unit.sv
// Combinational byte-lane datapath: extracts and extends load fields from a RAM
// word and merges right-aligned store data into the addressed bytes of a word.
module mem_lane_unit
  import mem_pkg::*;
#(
  parameter int DATA_WIDTH  = 64,
  parameter int OFFSET_BITS = 3
) (
  input  logic [DATA_WIDTH-1:0]  word,
  input  logic [DATA_WIDTH-1:0]  wdata,
  input  mem_size_e              size,
  input  logic                   is_unsigned,
  input  logic [OFFSET_BITS-1:0] offset,
  output logic [DATA_WIDTH-1:0]  load_data,
  output logic [DATA_WIDTH-1:0]  merged
);

  localparam int BYTES = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] shifted;
  logic [DATA_WIDTH-1:0] wdata_pos;
  logic [BYTES-1:0]      mask;
  logic                  sext;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path through the case statement can leave it unassigned and infer a latch.
    load_data = '0;
    sext      = 1'b0;
    shifted   = word >> {offset, 3'b000};
    case (size)
      MEM_B: begin
        sext      = shifted[7] & ~is_unsigned;
        load_data = {{(DATA_WIDTH-8){sext}}, shifted[7:0]};
      end
      MEM_H: begin
        sext      = shifted[15] & ~is_unsigned;
        load_data = {{(DATA_WIDTH-16){sext}}, shifted[15:0]};
      end
      MEM_W: begin
        sext      = shifted[31] & ~is_unsigned;
        load_data = {{(DATA_WIDTH-32){sext}}, shifted[31:0]};
      end
      default: load_data = shifted;
    endcase
  end

  always_comb begin
    wdata_pos = wdata << {offset, 3'b000};
    mask      = BYTES'(byte_mask(size, 32'(offset)));
    merged    = word;
    for (int b = 0; b < BYTES; b++) begin
      if (mask[b]) merged[8*b +: 8] = wdata_pos[8*b +: 8];
    end
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Load/store initiator for a word-organised data RAM: one request in flight,
// sub-word stores done as read-modify-write, registered response handshake.
module mem_access_ctrl
  import mem_pkg::*;
#(
  parameter int DATA_WIDTH  = 64,
  parameter int ADR_WIDTH   = DATA_WIDTH,
  parameter int OFFSET_BITS = 3
) (
  input logic              clk,
  input logic              rst_n,
  mem_access_ctrl_if.slave bus
);

  mem_state_e state, state_next;

  logic                  we_q;
  logic                  uns_q;
  mem_size_e             size_q;
  logic [ADR_WIDTH-1:0]  adr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] word_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  err_q;

  logic                  accept;
  logic                  misaligned;
  mem_size_e             req_size;
  logic [DATA_WIDTH-1:0] lane_word;
  logic [DATA_WIDTH-1:0] load_data;
  logic [DATA_WIDTH-1:0] merged;

  assign req_size   = mem_size_e'(bus.req_size);
  assign accept     = bus.req_valid && (state == IDLE);
  assign misaligned = is_misaligned(req_size, 32'(bus.req_adr[OFFSET_BITS-1:0]));

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (misaligned)                          state_next = RESP;
          else if (bus.req_we && req_size == MEM_D) state_next = WRITE;
          else                                      state_next = READ;
        end
      end
      READ:    state_next = we_q ? WRITE : RESP;
      WRITE:   state_next = RESP;
      RESP:    if (bus.rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: the datapath registers are reset too: rsp_rdata, rsp_err, mem_adr and
  // mem_din are all visible at the ports and must read zero out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      size_q  <= MEM_B;
      adr_q   <= '0;
      wdata_q <= '0;
      word_q  <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (accept) begin
        we_q    <= bus.req_we;
        uns_q   <= bus.req_unsigned;
        size_q  <= req_size;
        adr_q   <= bus.req_adr;
        wdata_q <= bus.req_wdata;
        rdata_q <= '0;
        err_q   <= misaligned;
      end
      if (state == READ) begin
        word_q <= bus.mem_dout;
        if (!we_q) rdata_q <= load_data;
      end
    end
  end

  // During READ the lane unit sees the live RAM word so loads register their
  // result in the same cycle; afterwards it works from the captured copy.
  assign lane_word = (state == READ) ? bus.mem_dout : word_q;

  mem_lane_unit #(
    .DATA_WIDTH  (DATA_WIDTH),
    .OFFSET_BITS (OFFSET_BITS)
  ) u_lane (
    .word        (lane_word),
    .wdata       (wdata_q),
    .size        (size_q),
    .is_unsigned (uns_q),
    .offset      (adr_q[OFFSET_BITS-1:0]),
    .load_data   (load_data),
    .merged      (merged)
  );

  assign bus.req_ready = (state == IDLE);
  assign bus.rsp_valid = (state == RESP);
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;
  assign bus.mem_we    = (state == WRITE);
  assign bus.mem_adr   = {adr_q[ADR_WIDTH-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
  assign bus.mem_din   = merged;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: byte-array reference memory, per-cycle comparison of
// the handshake and RAM port against it, plus directed literal expectations.
module tb_mem_access_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mem_access_ctrl_if #(.DATA_WIDTH(64), .ADR_WIDTH(64)) bus ();

  mem_access_ctrl #(.DATA_WIDTH(64), .ADR_WIDTH(64), .OFFSET_BITS(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // RAM: synchronous write, combinational read, 256 words; preload port for setup.
  logic [63:0] ram [0:255] = '{default: '0};
  logic        load_en;
  logic [7:0]  load_idx;
  logic [63:0] load_val;

  assign bus.mem_dout = ram[bus.mem_adr[10:3]];
  always @(posedge clk) begin
    if (load_en)         ram[load_idx] <= load_val;
    else if (bus.mem_we) ram[bus.mem_adr[10:3]] <= bus.mem_din;
  end

  // Reference model: byte-addressed little-endian memory and one pending request.
  logic [7:0]  ref_mem [0:2047] = '{default: '0};
  int          cyc = 0;
  logic        act = 1'b0;
  int          acc_cyc, exp_lat;
  logic        exp_err, exp_we;
  logic [63:0] exp_rd, exp_wadr, exp_din;

  task automatic model_accept();
    logic [63:0] a, v;
    int nb, lane;
    a    = bus.req_adr;
    nb   = 1 << bus.req_size;
    lane = int'(a[2:0]);
    exp_err = (lane % nb) != 0;
    exp_rd  = '0;
    exp_we  = 1'b0;
    exp_wadr = {a[63:3], 3'b000};
    exp_din  = '0;
    if (exp_err) begin
      exp_lat = 1;
    end else if (bus.req_we) begin
      exp_lat = (nb == 8) ? 2 : 3;
      exp_we  = 1'b1;
      for (int b = 0; b < 8; b++) exp_din[8*b +: 8] = ref_mem[11'({a[10:3], 3'b000} + b)];
      for (int i = 0; i < nb; i++) exp_din[8*(lane+i) +: 8] = bus.req_wdata[8*i +: 8];
    end else begin
      exp_lat = 2;
      v = '0;
      for (int i = 0; i < nb; i++) v[8*i +: 8] = ref_mem[11'(a[10:0] + i)];
      if (!bus.req_unsigned && nb < 8 && v[8*nb-1])
        for (int i = nb; i < 8; i++) v[8*i +: 8] = 8'hFF;
      exp_rd = v;
    end
  endtask

  always @(negedge clk) begin
    cyc++;
    if (load_en)
      for (int b = 0; b < 8; b++) ref_mem[11'({load_idx, 3'b000} + b)] = load_val[8*b +: 8];
    if (!rst_n) begin
      act = 1'b0;
      check("rst_req_ready", bus.req_ready, 1);
      check("rst_rsp_valid", bus.rsp_valid, 0);
      check("rst_rsp_err",   bus.rsp_err, 0);
      check("rst_rsp_rdata", bus.rsp_rdata, 0);
      check("rst_mem_we",    bus.mem_we, 0);
      check("rst_mem_adr",   bus.mem_adr, 0);
      check("rst_mem_din",   bus.mem_din, 0);
    end else if (act) begin
      check("busy_req_ready", bus.req_ready, 0);
      check("rsp_valid_timing", bus.rsp_valid, (cyc >= acc_cyc + exp_lat) ? 1 : 0);
      check("mem_we_timing", bus.mem_we, (exp_we && cyc == acc_cyc + exp_lat - 1) ? 1 : 0);
      if (exp_we && cyc == acc_cyc + exp_lat - 1) begin
        check("mem_adr", bus.mem_adr, exp_wadr);
        check("mem_din", bus.mem_din, exp_din);
        for (int b = 0; b < 8; b++) ref_mem[11'({exp_wadr[10:3], 3'b000} + b)] = exp_din[8*b +: 8];
      end
      if (cyc >= acc_cyc + exp_lat) begin
        check("rsp_err",   bus.rsp_err, exp_err);
        check("rsp_rdata", bus.rsp_rdata, exp_rd);
        if (bus.rsp_ready) act = 1'b0;
      end
      if (cyc > acc_cyc + exp_lat + 40) begin
        check("model_timeout", 1, 0);
        act = 1'b0;
      end
    end else begin
      check("idle_req_ready", bus.req_ready, 1);
      check("idle_rsp_valid", bus.rsp_valid, 0);
      check("idle_mem_we",    bus.mem_we, 0);
      if (bus.req_valid && bus.req_ready) begin
        act     = 1'b1;
        acc_cyc = cyc;
        model_accept();
      end
    end
  end

  // Directed request driver; reports what the handshake and RAM port showed.
  logic [63:0] r_rd, r_wadr, r_wdin;
  logic        r_err;
  int          r_lat, r_we_cnt;

  task automatic run_req(input logic we, input logic [1:0] sz, input logic uns,
                         input logic [63:0] adr, input logic [63:0] wd, input int hold);
    logic ok;
    r_rd = '0; r_err = 1'b0; r_lat = 0; r_we_cnt = 0; r_wadr = '0; r_wdin = '0;
    @(posedge clk); #1;
    bus.req_valid = 1'b1; bus.req_we = we; bus.req_size = sz; bus.req_unsigned = uns;
    bus.req_adr = adr; bus.req_wdata = wd; bus.rsp_ready = (hold == 0);
    ok = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (bus.req_ready) begin ok = 1'b1; break; end
    end
    check("req_accepted", ok, 1);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    ok = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (bus.mem_we) begin r_we_cnt++; r_wadr = bus.mem_adr; r_wdin = bus.mem_din; end
      if (bus.rsp_valid) begin
        r_lat = c; r_rd = bus.rsp_rdata; r_err = bus.rsp_err; ok = 1'b1;
        break;
      end
    end
    check("rsp_arrived", ok, 1);
    if (ok) begin
      for (int h = 0; h < hold; h++) begin
        @(negedge clk);
        check("hold_valid", bus.rsp_valid, 1);
        check("hold_rdata", bus.rsp_rdata, r_rd);
        check("hold_err",   bus.rsp_err, r_err);
        check("hold_req_ready", bus.req_ready, 0);
      end
      if (hold > 0) begin @(posedge clk); #1; bus.rsp_ready = 1'b1; end
      @(posedge clk); #1;
    end
    bus.rsp_ready = 1'b0;
  endtask

  task automatic load_word(input logic [7:0] idx, input logic [63:0] val);
    load_en = 1'b1; load_idx = idx; load_val = val;
    @(posedge clk); #1;
    load_en = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    load_en = 1'b0; load_idx = '0; load_val = '0;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = 2'd0; bus.req_unsigned = 1'b0;
    bus.req_adr = '0; bus.req_wdata = '0; bus.rsp_ready = 1'b0;
    @(posedge clk); #1;
    load_word(8'h08, 64'h8877665544332211);
    load_word(8'h09, 64'hFEDCBA9876543210);
    @(posedge clk); #1;
    rst_n = 1'b1;

    run_req(0, 2'd0, 0, 64'h47, '0, 0);
    check("lb_47_data", r_rd, 64'hFFFFFFFFFFFFFF88);
    check("lb_47_lat", r_lat, 2);
    check("lb_47_err", r_err, 0);
    run_req(0, 2'd1, 1, 64'h46, '0, 0);
    check("lhu_46_data", r_rd, 64'h0000000000008877);
    run_req(0, 2'd2, 0, 64'h44, '0, 0);
    check("lw_44_data", r_rd, 64'hFFFFFFFF88776655);
    run_req(0, 2'd0, 1, 64'h48, '0, 0);
    check("lbu_48_data", r_rd, 64'h10);
    run_req(0, 2'd2, 0, 64'h48, '0, 0);
    check("lw_48_data", r_rd, 64'h0000000076543210);
    run_req(0, 2'd1, 0, 64'h4E, '0, 0);
    check("lh_4e_data", r_rd, 64'hFFFFFFFFFFFFFEDC);

    run_req(1, 2'd0, 0, 64'h43, 64'hFFFFFFFFFFFFFFAB, 0);
    check("sb_43_lat", r_lat, 3);
    check("sb_43_we_cnt", r_we_cnt, 1);
    check("sb_43_adr", r_wadr, 64'h40);
    check("sb_43_din", r_wdin, 64'h88776655AB332211);
    check("sb_43_rdata", r_rd, 0);
    run_req(0, 2'd3, 0, 64'h40, '0, 0);
    check("ld_40_after_sb", r_rd, 64'h88776655AB332211);

    run_req(1, 2'd3, 0, 64'h48, 64'h0123456789ABCDEF, 0);
    check("sd_48_lat", r_lat, 2);
    check("sd_48_we_cnt", r_we_cnt, 1);
    check("sd_48_adr", r_wadr, 64'h48);
    run_req(0, 2'd3, 1, 64'h48, '0, 0);
    check("ld_48_after_sd", r_rd, 64'h0123456789ABCDEF);
    run_req(1, 2'd1, 0, 64'h4A, 64'h000000000000BEEF, 0);
    check("sh_4a_din", r_wdin, 64'h01234567BEEFCDEF);

    run_req(0, 2'd1, 0, 64'h41, '0, 0);
    check("lh_41_err", r_err, 1);
    check("lh_41_rdata", r_rd, 0);
    check("lh_41_lat", r_lat, 1);
    run_req(1, 2'd2, 0, 64'h42, 64'h11112222, 0);
    check("sw_42_err", r_err, 1);
    check("sw_42_lat", r_lat, 1);
    check("sw_42_we_cnt", r_we_cnt, 0);
    run_req(1, 2'd3, 0, 64'h44, 64'h5555, 0);
    check("sd_44_err", r_err, 1);

    run_req(0, 2'd0, 1, 64'h40, '0, 5);
    check("lbu_hold_data", r_rd, 64'h11);

    // Reset in the WRITE cycle of a sub-word store: the write must not land.
    @(posedge clk); #1;
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_size = 2'd2; bus.req_unsigned = 1'b0;
    bus.req_adr = 64'h40; bus.req_wdata = 64'hCAFEF00D; bus.rsp_ready = 1'b1;
    @(negedge clk);
    check("rst_case_ready", bus.req_ready, 1);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(posedge clk); #1;
    check("rst_case_we_high", bus.mem_we, 1);
    rst_n = 1'b0;
    #1;
    check("rst_case_we_drop", bus.mem_we, 0);
    check("rst_case_idle", bus.req_ready, 1);
    check("rst_case_no_rsp", bus.rsp_valid, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.rsp_ready = 1'b0;
    #1;
    check("rst_case_ready_after", bus.req_ready, 1);
    run_req(0, 2'd3, 0, 64'h40, '0, 0);
    check("ld_40_after_rst", r_rd, 64'h88776655AB332211);

    run_req(1, 2'd0, 0, 64'h40, 64'h5A, 0);
    run_req(1, 2'd0, 0, 64'h41, 64'h6B, 0);
    check("waw_second_din", r_wdin, 64'h88776655AB336B5A);
    run_req(0, 2'd3, 0, 64'h40, '0, 0);
    check("ld_40_after_waw", r_rd, 64'h88776655AB336B5A);

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
Initiator side of the data-RAM port: converts core load/store requests (byte/half/word/double, signed/unsigned) into whole-word accesses on the word-organised RAM (synchronous write, combinational read, byte address with low OFFSET_BITS ignored).
Sub-word stores are performed as read-modify-write. Load data is extracted, extended and returned through a registered response handshake.
Sits between the execute/memory stage and the data RAM instance.

Parameters:
DATA_WIDTH, `DATA_WIDTH (64), RAM word width in bits; must be 8*2**OFFSET_BITS
ADR_WIDTH, `DATA_WIDTH, byte-address width
OFFSET_BITS, 3, log2 of bytes per RAM word

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  controller can accept request (IDLE only)
req_we  in  1  1=store, 0=load
req_size  in  2  0=byte, 1=half, 2=word(32), 3=double(64)
req_unsigned  in  1  loads: zero-extend when 1, sign-extend when 0
req_adr  in  ADR_WIDTH  byte address
req_wdata  in  DATA_WIDTH  store data, right-aligned
rsp_valid  out  1  response present
rsp_ready  in  1  consumer accepts response
rsp_rdata  out  DATA_WIDTH  extended load data (0 for stores/errors)
rsp_err  out  1  misaligned access
mem_we  out  1  RAM write enable
mem_adr  out  ADR_WIDTH  RAM byte address, low OFFSET_BITS forced to 0
mem_din  out  DATA_WIDTH  RAM write data (merged word)
mem_dout  in  DATA_WIDTH  RAM combinational read data

Behaviour:
- States: IDLE, READ, WRITE, RESP. Reset: IDLE. req_ready=1, rsp_valid=0, rsp_err=0, rsp_rdata=0, mem_we=0, mem_adr=0, mem_din=0.
- Accept on req_valid && req_ready. Latch we, size, unsigned, adr, wdata.
- Alignment check at accept: adr mod 2**size != 0 -> err. Next state RESP with rsp_err=1, rsp_rdata=0. No RAM access.
- Aligned load: IDLE -> READ. READ captures mem_dout for the latched word, then -> RESP.
  - Lane = adr[OFFSET_BITS-1:0] bytes; extract size-wide field, sign/zero-extend.
  - size=3 ignores req_unsigned.
- Aligned store, size=3: IDLE -> WRITE directly.
- Aligned store, size<3: IDLE -> READ (capture word) -> WRITE. Only the addressed bytes of the captured word are replaced.
- WRITE: mem_we=1 for exactly one cycle with mem_din=merged word -> RESP.
- mem_we is a combinational decode of state==WRITE. It is never high outside WRITE.
- mem_adr = latched adr with offset bits cleared, stable from READ through WRITE.
- RESP: rsp_valid=1, outputs held stable until rsp_ready. On rsp_valid && rsp_ready -> IDLE. rsp_ready may be high on entry (one-cycle RESP).
- Latency, accept to rsp_valid (cycles): load 2; double store 2; sub-word store 3; misaligned 1.
- Throughput: one request in flight. req_ready=0 outside IDLE, so back-to-back requests are not accepted in the RESP-exit cycle.
- Write-after-write to the same word: the second request's READ observes the first's write, which completed in an earlier cycle.
- Reset mid-operation: immediate return to IDLE, mem_we drops asynchronously. A pending RMW is abandoned, RAM unchanged unless the WRITE edge already occurred. Response is discarded.
- Address bits above the RAM depth are passed through untouched; the RAM truncates them.

Decomposition:
- Shared package mem_pkg:
  - size enum (MEM_B, MEM_H, MEM_W, MEM_D)
  - state enum
  - function byte_mask(size, offset)
- One sub-module: mem_lane_unit, purely combinational. Outputs the extract+extend result for loads and the merge (old word, wdata, mask) for stores.
- FSM/handshake stays in mem_access_ctrl.

Test Plan:
- RAM word 0x40 = 0x8877665544332211. Load byte signed at 0x47 -> rsp_rdata=0xFFFFFFFFFFFFFF88, rsp_valid 2 cycles after accept, err=0.
- Same word, load half unsigned at 0x46 -> 0x0000000000008877. Load word signed at 0x44 -> 0xFFFFFFFF88776655.
- Store byte 0xAB at 0x43 -> mem_we one cycle, mem_adr=0x40, mem_din=0x88776655AB332211. rsp_valid 3 cycles after accept. Reload double returns the new value.
- Store double 0x0123456789ABCDEF at 0x48 -> no READ state, mem_we one cycle after accept, rsp 2 cycles after.
- Load half at 0x41, store word at 0x42 -> rsp_err=1 one cycle after accept, rsp_rdata=0, mem_we never asserted.
- Hold rsp_ready=0 for 5 cycles -> rsp_* stable, req_ready=0. Assert rst_n=0 during WRITE of a sub-word store -> mem_we drops immediately, state IDLE, req_ready=1 after release.
